cache_axi_mux: RTL
==================

// Module: cache_axi_mux
// PURPOSE
// - N-to-1 AXI4 multiplexer merging the cache subsystem's AXI masters (I$, D$ bypass, D$ refill,
//   optional extras) onto the single core AXI port.
// - Generalised successor of the fixed 3-port merge: parametrised port count, ID-prefix routing
//   instead of hard-coded IDs, round-robin AR/AW arbitration, and bounded outstanding W ordering
//   with back-pressure.
// PARAMETERS
// - NumSlv      3   number of upstream cache masters (>=2)
// - SlvIdWidth  4   AXI ID width on each upstream port
// - MaxWTrans   4   max AW accepted whose W burst is not yet complete (W-order FIFO depth, >=1)
// - slv_req_t / slv_rsp_t   logic   upstream AXI request/response structs (ID width SlvIdWidth)
// - mst_req_t / mst_rsp_t   logic   downstream structs, ID width SlvIdWidth+IdxW
// - IdxW = (NumSlv>1) ? $clog2(NumSlv) : 1   (derived, localparam)
// PORTS
// - clk_i       in   1                  clock, all logic on rising edge
// - rst_i       in   1                  synchronous active-high reset
// - slv_req_i   in   NumSlv x slv_req_t  upstream requests; index 0 = highest RR start
// - slv_rsp_o   out  NumSlv x slv_rsp_t  upstream responses
// - mst_req_o   out  mst_req_t           downstream request
// - mst_rsp_i   in   mst_rsp_t           downstream response
// - w_pending_o out  $clog2(MaxWTrans+1) AWs accepted with W burst open (debug/busy)
// BEHAVIOUR
// - Reset (rst_i=1 at edge): all valid/ready outputs 0 next cycle, RR pointers -> 0,
//   W FIFO empty, w_pending_o=0. Reset mid-burst drops all state; no partial bursts resumed.
// - ID prefix: downstream id = {port_index[IdxW-1:0], upstream id}; applies to AR and AW.
// - AR/AW arbiters: independent round-robin, each with IDLE/LOCKED state.
//   - IDLE: grant the first valid port at or after the RR pointer; drive mst valid the same cycle.
//   - If mst ready=0, go to LOCKED on that port; grant and payload held stable until handshake
//     (AXI valid stability).
//   - On handshake: pointer = granted+1 (wrap at NumSlv), return to IDLE.
// - AW gating: aw_valid to downstream forced 0 while W FIFO full (MaxWTrans entries); no grant
//   is taken.
// - W ordering FIFO: push granted port index on AW handshake.
//   - Pop on downstream W handshake with w.last.
//   - W mux selects the FIFO head. When empty: mst w_valid=0, all upstream w_ready=0.
//   - Simultaneous push and pop when full: the pop frees the slot, but the AW is still gated
//     that cycle (gating uses the registered full flag).
// - w_pending_o = FIFO occupancy.
// - R/B demux: route by id[SlvIdWidth+IdxW-1 -: IdxW]; strip the prefix before presenting
//   upstream. Downstream ready = ready of the selected port.
//   - Index >= NumSlv: response is accepted (ready=1) and dropped; sticky error flag set,
//     which raises a simulation-only assertion.
//   - R bursts are not interleave-checked; ordering is the downstream's responsibility.
// - All unused upstream response fields are broadcast (shared data/resp/last).
// CONFIGURATION
// - CACHE_AXI_MUX_W_FALLTHROUGH_EN defined:
//   - W FIFO is fall-through: W beats may be forwarded in the same cycle as their AW handshake
//     (select from the incoming index when the FIFO is empty).
//   - Zero added W latency.
// - Not defined:
//   - W is forwarded at the earliest one cycle after the AW handshake.
//   - Register-only select path; no AW->W combinational path.
// TESTING
// - Reset: hold rst_i 2 cycles with all inputs valid
//   -> every valid/ready output 0, w_pending_o=0.
// - RR fairness: NumSlv=3, AR valid on ports 0,1,2 continuously, ar_ready=1
//   -> grant order 0,1,2,0,1,2; downstream ids 6'b00xxxx, 6'b01xxxx, 6'b10xxxx.
// - Stability: ar_ready=0 for 5 cycles while port 2 requests and port 0 later asserts
//   -> ar payload and grant stay on port 2 until handshake.
// - W ordering: AW from port 2 (len=3), then port 1 (len=0); W offered on both
//   -> 4 beats from port 2, then 1 beat from port 1; w_pending_o 2->1->0.
// - Full: MaxWTrans=4, 4 AWs accepted, no W
//   -> 5th AW sees aw_valid=0 downstream; after one last-beat W, accepted the next cycle.
// - Response routing: B with id=6'b01_0011 and R with id=6'b11_0000 (NumSlv=3)
//   -> B to port 1 with id 4'b0011; R dropped with r_ready=1 and error flag set.

Source files
------------

// File: rtl/cache_axi_mux_if.sv
// ----------------------------------------------------------------------------
// cache_axi_mux_if
// Bundle of AXI4 channels for N parallel ports sharing one ID width.
// Upstream, the cache masters use one instance with N = number of masters.
// Downstream, the core port uses a second instance with N = 1.
//
// Parameters:
//   N      number of parallel AXI ports carried by this bundle
//   ID_W   AXI ID width
//   ADDR_W address width
//   DATA_W data width; the strobe width is DATA_W/8
//
// Modports:
//   master  drives AW/W/AR payload and valid, and drives B/R ready
//   slave   drives AW/W/AR ready, and drives B/R payload and valid
// ----------------------------------------------------------------------------
interface cache_axi_mux_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic [N-1:0]               aw_valid;
  logic [N-1:0]               aw_ready;
  logic [N-1:0][ID_W-1:0]     aw_id;
  logic [N-1:0][ADDR_W-1:0]   aw_addr;
  logic [N-1:0][7:0]          aw_len;

  logic [N-1:0]               w_valid;
  logic [N-1:0]               w_ready;
  logic [N-1:0][DATA_W-1:0]   w_data;
  logic [N-1:0][DATA_W/8-1:0] w_strb;
  logic [N-1:0]               w_last;

  logic [N-1:0]               b_valid;
  logic [N-1:0]               b_ready;
  logic [N-1:0][ID_W-1:0]     b_id;
  logic [N-1:0][1:0]          b_resp;

  logic [N-1:0]               ar_valid;
  logic [N-1:0]               ar_ready;
  logic [N-1:0][ID_W-1:0]     ar_id;
  logic [N-1:0][ADDR_W-1:0]   ar_addr;
  logic [N-1:0][7:0]          ar_len;

  logic [N-1:0]               r_valid;
  logic [N-1:0]               r_ready;
  logic [N-1:0][ID_W-1:0]     r_id;
  logic [N-1:0][DATA_W-1:0]   r_data;
  logic [N-1:0][1:0]          r_resp;
  logic [N-1:0]               r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, input aw_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input  b_valid, b_id, b_resp, output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, input ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, output aw_ready,
    input  w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_id, b_resp, input b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, input r_ready
  );
endinterface

// File: rtl/cache_axi_mux.sv
// ----------------------------------------------------------------------------
// cache_axi_mux
// N-to-1 AXI4 multiplexer that merges the cache masters onto the core AXI port.
// - AR and AW each have an independent round-robin arbiter. Each arbiter locks
//   onto its granted port until the handshake completes.
// - The downstream ID is {port index, upstream id}.
// - A W-order FIFO holds the granted AW port indices. The head of this FIFO
//   selects the W source. No new AW is granted while the FIFO is full.
// - R and B are routed back using the ID prefix, and the prefix is stripped.
//   A response whose prefix does not name a port is accepted and discarded,
//   and route_err_r is set and stays set.
//
// Ports:
//   clk_i        clock; all logic runs on the rising edge
//   rst_i        synchronous active-high reset
//   slv          upstream bundle (NumSlv ports, ID width SlvIdWidth)
//   mst          downstream bundle (1 port, ID width SlvIdWidth+IdxW)
//   w_pending_o  number of accepted AWs whose W burst is still open
//
// Build option: CACHE_AXI_MUX_W_FALLTHROUGH_EN
//   defined   - W may be forwarded in the same cycle as its AW handshake
//   undefined - the W select comes only from the registered FIFO head
// ----------------------------------------------------------------------------

// Round-robin arbiter with an IDLE/LOCKED state. The grant stays on one port
// from its first valid cycle until the handshake completes.
module cache_axi_mux_rr_arb #(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            gate_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [IdxW-1:0] sel_o,
  output logic            hs_o
);
  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  arb_state_e      state_r, state_s;
  logic [IdxW-1:0] ptr_r, ptr_s, lock_r, lock_s;
  logic [IdxW-1:0] first_s;
  logic            found_s;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (32'(idx) >= N - 32'd1) return '0;
    else                       return idx + IdxW'(1);
  endfunction

  // Find the first requesting port at or after the round-robin pointer.
  always_comb begin
    int k;
    k       = 0;
    found_s = 1'b0;
    first_s = '0;
    for (int i = 0; i < int'(N); i++) begin
      k = int'(ptr_r) + i;
      if (k >= int'(N)) k = k - int'(N);
      else              k = k;
      if (!found_s && req_i[k]) begin
        found_s = 1'b1;
        first_s = IdxW'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic and grant outputs.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    lock_s  = lock_r;
    valid_o = 1'b0;
    sel_o   = lock_r;
    hs_o    = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (found_s && !gate_i) begin
          valid_o = 1'b1;
          sel_o   = first_s;
          if (ready_i) begin
            hs_o  = 1'b1;
            ptr_s = next_idx(first_s);
          end else begin
            state_s = ARB_LOCKED;
            lock_s  = first_s;
          end
        end else begin
          sel_o = ptr_r;
        end
      end
      ARB_LOCKED: begin
        valid_o = req_i[lock_r];
        if (req_i[lock_r] && ready_i) begin
          hs_o    = 1'b1;
          ptr_s   = next_idx(lock_r);
          state_s = ARB_IDLE;
        end else begin
          state_s = ARB_LOCKED;
        end
      end
      default: state_s = ARB_IDLE;
    endcase
    // While reset is asserted, no grant is visible on any output.
    if (rst_i) begin
      valid_o = 1'b0;
      hs_o    = 1'b0;
    end else begin
      valid_o = valid_o;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ARB_IDLE;
      ptr_r   <= '0;
      lock_r  <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      lock_r  <= lock_s;
    end
  end
endmodule

module cache_axi_mux #(
  parameter  int unsigned NumSlv     = 3,
  parameter  int unsigned SlvIdWidth = 4,
  parameter  int unsigned MaxWTrans  = 4,
  localparam int unsigned IdxW       = (NumSlv > 1) ? $clog2(NumSlv) : 1,
  localparam int unsigned PendW      = $clog2(MaxWTrans + 1),
  localparam int unsigned PtrW       = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cache_axi_mux_if.slave   slv,
  cache_axi_mux_if.master  mst,
  output logic [PendW-1:0] w_pending_o
);
  logic            ar_valid_s, ar_hs_s, aw_valid_s, aw_hs_s;
  logic [IdxW-1:0] ar_sel_s, aw_sel_s;

  logic [IdxW-1:0] wfifo_mem_r [MaxWTrans];
  logic [PtrW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PendW-1:0] cnt_r;
  logic            w_full_s, w_empty_s, w_act_s, w_hs_s, w_pop_s;
  logic [IdxW-1:0] w_sel_s;

  logic [IdxW-1:0] r_idx_s, b_idx_s;
  logic            r_hit_s, b_hit_s;
  logic            route_err_r;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (32'(p) >= MaxWTrans - 32'd1) return '0;
    else                             return p + PtrW'(1);
  endfunction

  assign w_full_s  = (cnt_r == PendW'(MaxWTrans));
  assign w_empty_s = (cnt_r == '0);

  cache_axi_mux_rr_arb #(.N(NumSlv)) u_ar_arb (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(slv.ar_valid), .gate_i(1'b0),
    .ready_i(mst.ar_ready[0]), .valid_o(ar_valid_s), .sel_o(ar_sel_s), .hs_o(ar_hs_s)
  );

  // The full flag is registered, so a pop in the current cycle does not
  // release the AW gate until the following cycle.
  cache_axi_mux_rr_arb #(.N(NumSlv)) u_aw_arb (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(slv.aw_valid), .gate_i(w_full_s),
    .ready_i(mst.aw_ready[0]), .valid_o(aw_valid_s), .sel_o(aw_sel_s), .hs_o(aw_hs_s)
  );

  // Drive the AR/AW payload from the granted port, with the index prefixed to the ID.
  always_comb begin
    mst.ar_valid[0] = ar_valid_s;
    mst.ar_id[0]    = {ar_sel_s, slv.ar_id[ar_sel_s]};
    mst.ar_addr[0]  = slv.ar_addr[ar_sel_s];
    mst.ar_len[0]   = slv.ar_len[ar_sel_s];
    slv.ar_ready    = '0;
    slv.ar_ready[ar_sel_s] = ar_hs_s;
    mst.aw_valid[0] = aw_valid_s;
    mst.aw_id[0]    = {aw_sel_s, slv.aw_id[aw_sel_s]};
    mst.aw_addr[0]  = slv.aw_addr[aw_sel_s];
    mst.aw_len[0]   = slv.aw_len[aw_sel_s];
    slv.aw_ready    = '0;
    slv.aw_ready[aw_sel_s] = aw_hs_s;
  end

  // Choose the W source: the FIFO head, or in fall-through mode the AW being accepted now.
  always_comb begin
    w_sel_s = wfifo_mem_r[rd_ptr_r];
    w_act_s = !w_empty_s;
`ifdef CACHE_AXI_MUX_W_FALLTHROUGH_EN
    if (w_empty_s) begin
      w_sel_s = aw_sel_s;
      w_act_s = aw_hs_s;
    end else begin
      w_sel_s = wfifo_mem_r[rd_ptr_r];
    end
`endif
    if (rst_i) w_act_s = 1'b0;
    else       w_act_s = w_act_s;
  end

  // W data path; a beat that completes a burst (last set) pops the order FIFO.
  always_comb begin
    mst.w_valid[0] = w_act_s & slv.w_valid[w_sel_s];
    mst.w_data[0]  = slv.w_data[w_sel_s];
    mst.w_strb[0]  = slv.w_strb[w_sel_s];
    mst.w_last[0]  = slv.w_last[w_sel_s];
    slv.w_ready    = '0;
    slv.w_ready[w_sel_s] = w_act_s & mst.w_ready[0];
    w_hs_s  = w_act_s & slv.w_valid[w_sel_s] & mst.w_ready[0];
    w_pop_s = w_hs_s & slv.w_last[w_sel_s];
  end

  // W-order FIFO storage; entries need no reset because the pointers qualify them.
  always_ff @(posedge clk_i) begin
    if (aw_hs_s) wfifo_mem_r[wr_ptr_r] <= aw_sel_s;
  end

  // W-order FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (aw_hs_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (w_pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({aw_hs_s, w_pop_s})
        2'b10:   cnt_r <= cnt_r + PendW'(1);
        2'b01:   cnt_r <= cnt_r - PendW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign w_pending_o = cnt_r;

  // Route R and B back by the ID prefix. All payload fields go to every port;
  // only the valid of the addressed port is raised.
  always_comb begin
    r_idx_s = mst.r_id[0][SlvIdWidth+IdxW-1 -: IdxW];
    b_idx_s = mst.b_id[0][SlvIdWidth+IdxW-1 -: IdxW];
    r_hit_s = (32'(r_idx_s) < NumSlv);
    b_hit_s = (32'(b_idx_s) < NumSlv);
    for (int unsigned p = 0; p < NumSlv; p++) begin
      slv.r_valid[p] = !rst_i & mst.r_valid[0] & r_hit_s & (r_idx_s == IdxW'(p));
      slv.r_id[p]    = mst.r_id[0][SlvIdWidth-1:0];
      slv.r_data[p]  = mst.r_data[0];
      slv.r_resp[p]  = mst.r_resp[0];
      slv.r_last[p]  = mst.r_last[0];
      slv.b_valid[p] = !rst_i & mst.b_valid[0] & b_hit_s & (b_idx_s == IdxW'(p));
      slv.b_id[p]    = mst.b_id[0][SlvIdWidth-1:0];
      slv.b_resp[p]  = mst.b_resp[0];
    end
    // A response with an unknown prefix is accepted so the downstream side cannot stall on it.
    if (rst_i)        mst.r_ready[0] = 1'b0;
    else if (r_hit_s) mst.r_ready[0] = slv.r_ready[r_idx_s];
    else              mst.r_ready[0] = 1'b1;
    if (rst_i)        mst.b_ready[0] = 1'b0;
    else if (b_hit_s) mst.b_ready[0] = slv.b_ready[b_idx_s];
    else              mst.b_ready[0] = 1'b1;
  end

  // Sticky misroute flag; a simulation checker can monitor it.
  always_ff @(posedge clk_i) begin
    if (rst_i) route_err_r <= 1'b0;
    else       route_err_r <= route_err_r | (mst.r_valid[0] & !r_hit_s) | (mst.b_valid[0] & !b_hit_s);
  end
endmodule
